// File: rtl/counter_cmd_ctrl_if.sv
// Push-button and command bundle between the button front end and the 5-bit counter.
interface counter_cmd_ctrl_if;
    logic Btn_Load;
    logic Btn_Up;
    logic Btn_Down;
    logic High;
    logic Low;
    logic Load;
    logic Up;
    logic Down;
    logic Held;

    // Master drives buttons and counter flags; slave (this block) returns commands.
    modport master (
        output Btn_Load, Btn_Up, Btn_Down, High, Low,
        input  Load, Up, Down, Held
    );

    modport slave (
        input  Btn_Load, Btn_Up, Btn_Down, High, Low,
        output Load, Up, Down, Held
    );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// Button conditioning for the up/down counter: synchronize, debounce, arbitrate,
// auto-repeat on hold and saturate against the counter's High/Low flags.
module counter_cmd_ctrl #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned REPEAT_DELAY = 16,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned TMR_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    counter_cmd_ctrl_if.slave  bus
);

    localparam int unsigned NBTN     = 3;
    localparam int unsigned BTN_LOAD = 0;
    localparam int unsigned BTN_UP   = 1;
    localparam int unsigned BTN_DOWN = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2
    } cmd_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] deb;

    assign raw = {bus.Btn_Down, bus.Btn_Up, bus.Btn_Load};

    // Two-flop synchronizer per button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level flips after DEB_CYCLES consecutive mismatching samples.
    for (genvar g = 0; g < NBTN; g++) begin : g_deb
        logic [TMR_W-1:0] deb_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                deb[g]  <= 1'b0;
                deb_cnt <= '0;
            end else if (sync2[g] == deb[g]) begin
                deb_cnt <= '0;
            end else if (deb_cnt == TMR_W'(DEB_CYCLES - 1)) begin
                deb[g]  <= ~deb[g];
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + TMR_W'(1);
            end
        end
    end

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fire;
    logic             cap_level;
    logic             load_d, up_d, down_d, held_d;
    logic             load_q, up_q, down_q, held_q;

    // Only Up/Down ever reach DELAY/REPEAT, so the captured level is one of those two.
    assign cap_level = (cmd_q == CMD_DOWN) ? deb[BTN_DOWN] : deb[BTN_UP];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= CMD_LOAD;
            tmr_q   <= '0;
            load_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tmr_q   <= tmr_d;
            load_q  <= load_d;
            up_q    <= up_d;
            down_q  <= down_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tmr_d   = tmr_q;
        fire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (deb[BTN_LOAD]) begin
                    cmd_d   = CMD_LOAD;
                    fire    = 1'b1;
                    state_d = WAIT_REL;
                end else if (deb[BTN_DOWN]) begin
                    cmd_d   = CMD_DOWN;
                    fire    = 1'b1;
                    tmr_d   = TMR_W'(REPEAT_DELAY - 1);
                    state_d = DELAY;
                end else if (deb[BTN_UP]) begin
                    cmd_d   = CMD_UP;
                    fire    = 1'b1;
                    tmr_d   = TMR_W'(REPEAT_DELAY - 1);
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!cap_level) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    fire    = 1'b1;
                    tmr_d   = TMR_W'(REPEAT_RATE - 1);
                    state_d = REPEAT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            WAIT_REL: begin
                if (deb == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturation masks only the pulse; timers and state still advance.
        load_d = fire && (cmd_d == CMD_LOAD);
        up_d   = fire && (cmd_d == CMD_UP) && !bus.High;
        down_d = fire && (cmd_d == CMD_DOWN) && !bus.Low;
        held_d = (state_d != IDLE);
    end

    assign bus.Load = load_q;
    assign bus.Up   = up_q;
    assign bus.Down = down_q;
    assign bus.Held = held_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Self-checking bench for counter_cmd_ctrl: reset vector table, directed hold
// sequences and randomized button traffic against a behavioural model.
module tb_counter_cmd_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 16;
    localparam int unsigned RR  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_cmd_ctrl_if bus ();

    counter_cmd_ctrl #(
        .DEB_CYCLES  (DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .TMR_W       (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "init";
    int ecount   = 0;
    logic [63:0] load_seen, up_seen, down_seen, held_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s edge %0d: got %0h expected %0h", phase, name, ecount, act, exp);
    endtask

    // Behavioural model: sync pipeline, sample-window debounce, hold age schedule.
    bit [2:0]     m_s1, m_s2, m_deb;
    bit [DEB-1:0] m_win [3];
    bit           m_hold;
    int           m_cap;
    int           m_age;
    bit           e_load, e_up, e_down, e_held;

    task automatic model_step(input bit r, input bit [2:0] raw, input bit hi, input bit lo);
        bit [2:0] old;
        int kind;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 3; i++) m_win[i] = '0;
            m_hold = 0; m_cap = 0; m_age = 0;
            e_load = 0; e_up = 0; e_down = 0; e_held = 0;
            return;
        end
        old  = m_deb;
        kind = -1;
        if (!m_hold) begin
            if (old != 0) begin
                m_cap  = old[0] ? 0 : (old[2] ? 2 : 1);
                m_hold = 1;
                m_age  = 0;
                kind   = m_cap;
            end
        end else if (m_cap == 0) begin
            if (old == 0) m_hold = 0;
        end else if (!old[m_cap]) begin
            m_hold = 0;
        end else begin
            m_age++;
            if (m_age >= int'(RD) && ((m_age - int'(RD)) % int'(RR)) == 0) kind = m_cap;
        end
        e_load = (kind == 0);
        e_up   = (kind == 1) && !hi;
        e_down = (kind == 2) && !lo;
        e_held = m_hold;
        for (int i = 0; i < 3; i++) begin
            m_win[i] = (m_win[i] << 1) | DEB'(m_s2[i]);
            if (m_deb[i] ? (m_win[i] == '0) : (&m_win[i])) m_deb[i] = ~m_deb[i];
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic drive(input bit r, input bit bl, input bit bu, input bit bd, input bit hi, input bit lo);
        rst          = r;
        bus.Btn_Load = bl;
        bus.Btn_Up   = bu;
        bus.Btn_Down = bd;
        bus.High     = hi;
        bus.Low      = lo;
        model_step(r, {bd, bu, bl}, hi, lo);
        @(posedge clk);
        #1;
        ecount++;
        if (ecount < 64) begin
            load_seen[ecount] = bus.Load;
            up_seen[ecount]   = bus.Up;
            down_seen[ecount] = bus.Down;
            held_seen[ecount] = bus.Held;
        end
    endtask

    // One cycle compared against the model on every output.
    task automatic step(input bit r, input bit bl, input bit bu, input bit bd, input bit hi, input bit lo);
        drive(r, bl, bu, bd, hi, lo);
        check("Load", 64'(bus.Load), 64'(e_load));
        check("Up",   64'(bus.Up),   64'(e_up));
        check("Down", 64'(bus.Down), 64'(e_down));
        check("Held", 64'(bus.Held), 64'(e_held));
        check("onehot", 64'(int'(bus.Load) + int'(bus.Up) + int'(bus.Down) <= 1), 64'(1));
    endtask

    task automatic start_phase(input string name);
        phase = name;
        step(1, 0, 0, 0, 0, 0);
        ecount    = 0;
        load_seen = '0; up_seen = '0; down_seen = '0; held_seen = '0;
    endtask

    function automatic logic [63:0] bit_at(input int e);
        return 64'(1) << e;
    endfunction

    function automatic logic [63:0] edges_upto(input int n);
        return ((64'(1) << (n + 1)) - 64'(1)) & ~64'(1);
    endfunction

    typedef struct {
        bit r, bl, bu, bd, hi, lo;
        bit el, eu, ed, eh;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [63:0] exp_mask;
        bus.Btn_Load = 1; bus.Btn_Up = 1; bus.Btn_Down = 1; bus.High = 0; bus.Low = 0;

        // Reset with all buttons held; Load wins exactly DEB+3 edges after release of rst.
        for (int i = 0; i < 11; i++) begin
            vecs[i] = '{r: (i < 3), bl: 1, bu: 1, bd: 1, hi: 0, lo: 0,
                        el: (i == 9), eu: 0, ed: 0, eh: (i >= 9)};
        end
        phase = "reset_table";
        for (int i = 0; i < 11; i++) begin
            if (i == 3) ecount = 0;
            drive(vecs[i].r, vecs[i].bl, vecs[i].bu, vecs[i].bd, vecs[i].hi, vecs[i].lo);
            check("Load", 64'(bus.Load), 64'(vecs[i].el));
            check("Up",   64'(bus.Up),   64'(vecs[i].eu));
            check("Down", 64'(bus.Down), 64'(vecs[i].ed));
            check("Held", 64'(bus.Held), 64'(vecs[i].eh));
        end

        // Bouncing Up button never settles.
        start_phase("bounce");
        for (int k = 1; k <= 30; k++) step(0, 0, ((k - 1) / 2) % 2 == 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0);
        check("up_seen", up_seen, '0);
        check("held_seen", held_seen, '0);

        // Short Up press: one pulse, Held 7..18.
        start_phase("short_up");
        for (int k = 1; k <= 12; k++) step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0, 0);
        check("up_seen", up_seen, bit_at(7));
        exp_mask = '0;
        for (int e = 7; e <= 18; e++) exp_mask |= bit_at(e);
        check("held_seen", held_seen, exp_mask);

        // Long Down hold: initial delay then repeat cadence.
        start_phase("down_repeat");
        for (int k = 1; k <= 45; k++) step(0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 0, 0, 0, 0);
        exp_mask = bit_at(7);
        for (int e = 23; e <= 43; e += 4) exp_mask |= bit_at(e);
        check("down_in_hold", down_seen & edges_upto(45), exp_mask);
        check("down_after_deb", down_seen >> 52, '0);

        // All three pressed: Load only; then Up alone afterwards.
        start_phase("all_pressed");
        for (int k = 1; k <= 40; k++) step(0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0, 0);
        check("load_seen", load_seen, bit_at(7));
        check("up_seen", up_seen, '0);
        check("down_seen", down_seen, '0);
        ecount = 0;
        load_seen = '0; up_seen = '0; down_seen = '0; held_seen = '0;
        for (int k = 1; k <= 12; k++) step(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0, 0);
        check("up_after", up_seen, bit_at(7));

        // Up held against High=1 through edge 25; cadence is unchanged.
        start_phase("saturate_up");
        for (int k = 1; k <= 40; k++) step(0, 0, 1, 0, k <= 25, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0, 0);
        exp_mask = '0;
        for (int e = 27; e <= 39; e += 4) exp_mask |= bit_at(e);
        check("up_in_hold", up_seen & edges_upto(40), exp_mask);

        // Random traffic with glitches, flags and occasional resets.
        phase = "random";
        for (int seg = 0; seg < 150; seg++) begin
            int unsigned pat;
            int unsigned len;
            pat = $urandom_range(0, 7);
            len = $urandom_range(1, 40);
            for (int unsigned k = 0; k < len; k++) begin
                step($urandom_range(0, 299) == 0,
                     pat[0] ^ ($urandom_range(0, 15) == 0),
                     pat[1] ^ ($urandom_range(0, 15) == 0),
                     pat[2] ^ ($urandom_range(0, 15) == 0),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
